// File: rtl/sdram_rd_checker_pkg.sv
// -----------------------------------------------------------------------------
// sdram_rd_checker_pkg
// Shared types and constants for the SDRAM read-back checker.
//   state_t      : run sequencer states
//   ERR_CNT_W    : width of the mismatch counter
//   ERR_CNT_SAT  : value at which the mismatch counter stops
// Optional feature macro used by this slice: SDRAM_RD_CHECKER_ERR_CAPTURE_EN
// -----------------------------------------------------------------------------
package sdram_rd_checker_pkg;

  localparam int unsigned ERR_CNT_W = 16;
  localparam logic [ERR_CNT_W-1:0] ERR_CNT_SAT = 16'hFFFF;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    SETTLE = 3'd2,
    READ   = 3'd3,
    DRAIN  = 3'd4,
    FINISH = 3'd5
  } state_t;

endpackage

// File: rtl/sdram_rd_checker_cmp.sv
// -----------------------------------------------------------------------------
// sdram_rd_cmp
// Expected-pattern generator, registered read-data comparator, saturating
// mismatch counter and (optionally) first-error capture.
// The expected value for word i is i mod 2^DATA_W.
//
// Ports
//   i_clk          : clock, rising edge
//   i_rst_n        : asynchronous active-low reset
//   i_clear        : start of a new run; clears counter and first-error capture
//   i_req          : read strobe issued this cycle
//   i_req_idx      : word index of the read issued this cycle
//   i_rd_data      : read data, valid the cycle after i_req
//   o_err_cnt      : saturating mismatch count
//   o_first_addr   : word index of the first mismatch of the run
//   o_first_data   : data read at the first mismatch of the run
//   o_last_data    : most recently compared word
//
// Macro SDRAM_RD_CHECKER_ERR_CAPTURE_EN enables the first-error capture; when
// undefined o_first_addr/o_first_data are tied to zero.
// -----------------------------------------------------------------------------
module sdram_rd_cmp
  import sdram_rd_checker_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_clear,
  input  logic                 i_req,
  input  logic [ADDR_W-1:0]    i_req_idx,
  input  logic [DATA_W-1:0]    i_rd_data,
  output logic [ERR_CNT_W-1:0] o_err_cnt,
  output logic [ADDR_W-1:0]    o_first_addr,
  output logic [DATA_W-1:0]    o_first_data,
  output logic [DATA_W-1:0]    o_last_data
);

  logic                 r_cmp_vld;
  logic [ADDR_W-1:0]    r_cmp_idx;
  logic [ERR_CNT_W-1:0] r_err_cnt;
  logic [DATA_W-1:0]    r_last_data;
  logic [DATA_W-1:0]    w_expected;
  logic                 w_mismatch;

  // Size cast truncates (pattern wrap) or zero-extends the index as needed.
  assign w_expected = DATA_W'(r_cmp_idx);
  assign w_mismatch = r_cmp_vld && (i_rd_data != w_expected);

  // The request is registered so the compare lines up with the read data
  // arriving one cycle after the strobe.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cmp_vld   <= 1'b0;
      r_cmp_idx   <= '0;
      r_err_cnt   <= '0;
      r_last_data <= '0;
    end else begin
      r_cmp_vld <= i_req;
      r_cmp_idx <= i_req_idx;
      if (i_clear) begin
        r_err_cnt <= '0;
      end else if (w_mismatch && (r_err_cnt != ERR_CNT_SAT)) begin
        r_err_cnt <= r_err_cnt + 1'b1;
      end
      if (r_cmp_vld) begin
        r_last_data <= i_rd_data;
      end
    end
  end

  assign o_err_cnt   = r_err_cnt;
  assign o_last_data = r_last_data;

`ifdef SDRAM_RD_CHECKER_ERR_CAPTURE_EN
  logic              r_first_seen;
  logic [ADDR_W-1:0] r_first_addr;
  logic [DATA_W-1:0] r_first_data;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_first_seen <= 1'b0;
      r_first_addr <= '0;
      r_first_data <= '0;
    end else if (i_clear) begin
      r_first_seen <= 1'b0;
      r_first_addr <= '0;
      r_first_data <= '0;
    end else if (w_mismatch && !r_first_seen) begin
      r_first_seen <= 1'b1;
      r_first_addr <= r_cmp_idx;
      r_first_data <= i_rd_data;
    end
  end

  assign o_first_addr = r_first_addr;
  assign o_first_data = r_first_data;
`else
  assign o_first_addr = '0;
  assign o_first_data = '0;
`endif

endmodule

// File: rtl/sdram_rd_checker.sv
// -----------------------------------------------------------------------------
// sdram_rd_checker (top)
// Reads NUM_WORDS words from an SDRAM controller read port and checks each
// against the incrementing pattern i mod 2^DATA_W.
// Sequence: IDLE -> LOAD (RD_LOAD pulse) -> SETTLE (SETTLE_CYC cycles for
// controller prefetch) -> READ (RD_REQ = RD_READY) -> DRAIN -> FINISH.
//
// Ports
//   REF_CLK        in   clock, rising edge
//   RESET_N        in   asynchronous active-low reset
//   START          in   one-cycle pulse starting a run (ignored unless idle)
//   RD_READY       in   read FIFO not empty
//   RD_DATA        in   read FIFO data, valid one cycle after RD_REQ
//   RD_REQ         out  read strobe
//   RD_LOAD        out  read address reload pulse
//   BUSY           out  run in progress
//   DONE           out  run finished, held until next START
//   PASS           out  DONE with zero mismatches
//   ERR_CNT        out  saturating mismatch count
//   FIRST_ERR_ADDR out  word index of first mismatch
//   FIRST_ERR_DATA out  data read at first mismatch
//   LAST_DATA      out  last word received
//
// Macro SDRAM_RD_CHECKER_ERR_CAPTURE_EN enables first-error capture.
// -----------------------------------------------------------------------------
module sdram_rd_checker
  import sdram_rd_checker_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned NUM_WORDS  = 256,
  parameter int unsigned SETTLE_CYC = 64,
  localparam int unsigned AW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
  input  logic                 REF_CLK,
  input  logic                 RESET_N,
  input  logic                 START,
  input  logic                 RD_READY,
  input  logic [DATA_W-1:0]    RD_DATA,
  output logic                 RD_REQ,
  output logic                 RD_LOAD,
  output logic                 BUSY,
  output logic                 DONE,
  output logic                 PASS,
  output logic [ERR_CNT_W-1:0] ERR_CNT,
  output logic [AW-1:0]        FIRST_ERR_ADDR,
  output logic [DATA_W-1:0]    FIRST_ERR_DATA,
  output logic [DATA_W-1:0]    LAST_DATA
);

  state_t               r_state;
  logic [AW-1:0]        r_req_idx;
  logic [31:0]          r_settle_cnt;
  logic                 r_rd_load;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_pass;

  logic                 w_start_ok;
  logic                 w_rd_req;
  logic                 w_last_req;
  logic [ERR_CNT_W-1:0] w_err_cnt;

  // START is only honoured from IDLE, so it is dropped while busy and on the
  // FINISH cycle alike.
  assign w_start_ok = (r_state == IDLE) && START;
  assign w_rd_req   = (r_state == READ) && RD_READY;
  assign w_last_req = w_rd_req && (r_req_idx == AW'(NUM_WORDS - 1));

  always_ff @(posedge REF_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state      <= IDLE;
      r_req_idx    <= '0;
      r_settle_cnt <= '0;
      r_rd_load    <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start_ok) begin
            r_state   <= LOAD;
            r_rd_load <= 1'b1;
            r_busy    <= 1'b1;
            r_done    <= 1'b0;
            r_pass    <= 1'b0;
            r_req_idx <= '0;
          end
        end
        LOAD: begin
          r_rd_load    <= 1'b0;
          r_settle_cnt <= '0;
          r_state      <= (SETTLE_CYC == 0) ? READ : SETTLE;
        end
        SETTLE: begin
          if (r_settle_cnt == 32'(SETTLE_CYC - 1)) begin
            r_state <= READ;
          end else begin
            r_settle_cnt <= r_settle_cnt + 32'd1;
          end
        end
        READ: begin
          if (w_rd_req) begin
            r_req_idx <= r_req_idx + 1'b1;
          end
          if (w_last_req) begin
            r_state <= DRAIN;
          end
        end
        DRAIN: begin
          r_state <= FINISH;
        end
        FINISH: begin
          r_done  <= 1'b1;
          r_pass  <= (w_err_cnt == '0);
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  sdram_rd_cmp #(
    .DATA_W (DATA_W),
    .ADDR_W (AW)
  ) u_cmp (
    .i_clk        (REF_CLK),
    .i_rst_n      (RESET_N),
    .i_clear      (w_start_ok),
    .i_req        (w_rd_req),
    .i_req_idx    (r_req_idx),
    .i_rd_data    (RD_DATA),
    .o_err_cnt    (w_err_cnt),
    .o_first_addr (FIRST_ERR_ADDR),
    .o_first_data (FIRST_ERR_DATA),
    .o_last_data  (LAST_DATA)
  );

  assign RD_REQ  = w_rd_req;
  assign RD_LOAD = r_rd_load;
  assign BUSY    = r_busy;
  assign DONE    = r_done;
  assign PASS    = r_pass;
  assign ERR_CNT = w_err_cnt;

endmodule

// File: tb/tb_sdram_rd_checker.sv
// -----------------------------------------------------------------------------
// tb_sdram_rd_checker
// Three checker instances share one clock/reset:
//   A: defaults (256 words) - clean, injected errors, stalls, reset, re-START
//   B: 512 words            - pattern wrap
//   C: 65536 words          - error counter saturation
// Run results are queued when a run is launched and compared on DONE.
// -----------------------------------------------------------------------------
module tb_sdram_rd_checker;

`ifdef SDRAM_RD_CHECKER_ERR_CAPTURE_EN
  localparam bit CAP = 1'b1;
`else
  localparam bit CAP = 1'b0;
`endif

  typedef struct {
    logic [15:0] err;
    logic        pass;
    logic [15:0] fea;
    logic [7:0]  fed;
    logic [7:0]  last;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- DUT A ----------------
  logic        a_start, a_ready, a_req, a_load, a_busy, a_done, a_pass;
  logic [7:0]  a_data, a_fea, a_fed, a_last;
  logic [15:0] a_err;

  sdram_rd_checker #(.DATA_W(8), .NUM_WORDS(256), .SETTLE_CYC(64)) u_a (
    .REF_CLK(clk), .RESET_N(rst_n), .START(a_start), .RD_READY(a_ready),
    .RD_DATA(a_data), .RD_REQ(a_req), .RD_LOAD(a_load), .BUSY(a_busy),
    .DONE(a_done), .PASS(a_pass), .ERR_CNT(a_err), .FIRST_ERR_ADDR(a_fea),
    .FIRST_ERR_DATA(a_fed), .LAST_DATA(a_last)
  );

  // ---------------- DUT B ----------------
  logic        b_start, b_ready, b_req, b_load, b_busy, b_done, b_pass;
  logic [7:0]  b_data, b_fed, b_last;
  logic [8:0]  b_fea;
  logic [15:0] b_err;

  sdram_rd_checker #(.DATA_W(8), .NUM_WORDS(512), .SETTLE_CYC(64)) u_b (
    .REF_CLK(clk), .RESET_N(rst_n), .START(b_start), .RD_READY(b_ready),
    .RD_DATA(b_data), .RD_REQ(b_req), .RD_LOAD(b_load), .BUSY(b_busy),
    .DONE(b_done), .PASS(b_pass), .ERR_CNT(b_err), .FIRST_ERR_ADDR(b_fea),
    .FIRST_ERR_DATA(b_fed), .LAST_DATA(b_last)
  );

  // ---------------- DUT C ----------------
  logic        c_start, c_ready, c_req, c_load, c_busy, c_done, c_pass;
  logic [7:0]  c_data, c_fed, c_last;
  logic [15:0] c_fea, c_err;

  sdram_rd_checker #(.DATA_W(8), .NUM_WORDS(65536), .SETTLE_CYC(4)) u_c (
    .REF_CLK(clk), .RESET_N(rst_n), .START(c_start), .RD_READY(c_ready),
    .RD_DATA(c_data), .RD_REQ(c_req), .RD_LOAD(c_load), .BUSY(c_busy),
    .DONE(c_done), .PASS(c_pass), .ERR_CNT(c_err), .FIRST_ERR_ADDR(c_fea),
    .FIRST_ERR_DATA(c_fed), .LAST_DATA(c_last)
  );

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic sb_cmp(input string who, input logic busy, input logic [15:0] err,
                        input logic pass, input logic [15:0] fea, input logic [7:0] fed,
                        input logic [7:0] last);
    exp_t e;
    chk({who, "_sb_nonempty"}, 32'(sb.size() > 0), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({who, "_busy"}, 32'(busy), 0);
      chk({who, "_err_cnt"}, 32'(err), 32'(e.err));
      chk({who, "_pass"}, 32'(pass), 32'(e.pass));
      chk({who, "_first_addr"}, 32'(fea), 32'(e.fea));
      chk({who, "_first_data"}, 32'(fed), 32'(e.fed));
      chk({who, "_last_data"}, 32'(last), 32'(e.last));
    end
  endtask

  // ---------------- DUT A memory model / monitor ----------------
  logic [7:0] mem [256];
  int  a_reqs, a_loads, a_noready, a_first, a_lastc, a_loadc, a_didx, a_dones, a_tog;
  logic a_req_q = 1'b0, a_done_q = 1'b0, a_stall = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (a_req) begin
      if (!a_ready) a_noready++;
      if (a_reqs == 0) a_first = cyc;
      a_lastc = cyc;
      a_reqs++;
    end
    if (a_load) begin
      a_loads++;
      a_loadc = cyc;
    end
    a_req_q = a_req;
    if (a_done && !a_done_q) begin
      a_dones++;
      sb_cmp("a", a_busy, a_err, a_pass, 16'(a_fea), a_fed, a_last);
    end
    a_done_q = a_done;
  end

  // Read data is presented the cycle after the strobe.
  always @(posedge clk) begin
    #1;
    if (a_req_q) begin
      a_data = mem[a_didx % 256];
      a_didx++;
    end
    if (a_stall) begin
      if (a_tog == 2) begin
        a_ready = ~a_ready;
        a_tog   = 0;
      end else begin
        a_tog++;
      end
    end
  end

  // ---------------- DUT B / C drivers ----------------
  int   b_reqs, b_loads, b_didx, b_dones, c_reqs, c_loads, c_didx, c_dones;
  logic b_req_q = 1'b0, b_done_q = 1'b0, c_req_q = 1'b0, c_done_q = 1'b0;

  always @(negedge clk) begin
    if (b_req) b_reqs++;
    if (b_load) b_loads++;
    if (c_req) c_reqs++;
    if (c_load) c_loads++;
    b_req_q = b_req;
    c_req_q = c_req;
    if (b_done && !b_done_q) begin
      b_dones++;
      sb_cmp("b", b_busy, b_err, b_pass, 16'(b_fea), b_fed, b_last);
    end
    if (c_done && !c_done_q) begin
      c_dones++;
      sb_cmp("c", c_busy, c_err, c_pass, c_fea, c_fed, c_last);
    end
    b_done_q = b_done;
    c_done_q = c_done;
  end

  always @(posedge clk) begin
    #1;
    if (b_req_q) begin
      b_data = 8'(b_didx);
      b_didx++;
    end
    if (c_req_q) begin
      c_data = ~8'(c_didx);
      c_didx++;
    end
  end

  // ---------------- helpers ----------------
  function automatic exp_t a_model();
    exp_t e;
    bit   seen;
    e.err  = '0;
    e.fea  = '0;
    e.fed  = '0;
    seen   = 1'b0;
    for (int i = 0; i < 256; i++) begin
      if (mem[i] != 8'(i)) begin
        if (!seen && CAP) begin
          e.fea = 16'(i);
          e.fed = mem[i];
        end
        seen  = 1'b1;
        e.err = e.err + 16'd1;
      end
    end
    e.pass = (e.err == 16'd0);
    e.last = mem[255];
    return e;
  endfunction

  function automatic int dones(input int which);
    case (which)
      0:       return a_dones;
      1:       return b_dones;
      default: return c_dones;
    endcase
  endfunction

  task automatic wait_done(input string tag, input int which, input int budget);
    int n;
    int base;
    n    = 0;
    base = dones(which);
    while (dones(which) == base && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done_seen"}, 32'(dones(which) != base), 1);
  endtask

  task automatic a_begin();
    a_reqs = 0; a_loads = 0; a_noready = 0; a_first = 0; a_lastc = 0;
    a_loadc = 0; a_didx = 0;
    sb.push_back(a_model());
    @(posedge clk); #1 a_start = 1'b1;
    @(posedge clk); #1 a_start = 1'b0;
    @(negedge clk);
    chk("a_busy_after_start", 32'(a_busy), 1);
    chk("a_done_cleared", 32'(a_done), 0);
  endtask

  task automatic a_wait_reqs(input string tag, input int target);
    int n;
    n = 0;
    while (a_reqs < target && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(a_reqs >= target), 1);
  endtask

  task automatic a_run_counts(input string tag);
    chk({tag, "_req_cnt"}, 32'(a_reqs), 256);
    chk({tag, "_load_cnt"}, 32'(a_loads), 1);
    chk({tag, "_req_no_ready"}, 32'(a_noready), 0);
  endtask

  // ---------------- main sequence ----------------
  exp_t eb, ec;

  initial begin
    rst_n = 1'b0;
    a_start = 1'b0; a_ready = 1'b1; a_data = '0;
    b_start = 1'b0; b_ready = 1'b1; b_data = '0;
    c_start = 1'b0; c_ready = 1'b1; c_data = '0;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);

    repeat (3) @(negedge clk);
    chk("rst_outputs", 32'({a_req, a_load, a_busy, a_done, a_pass}), 0);
    chk("rst_err_cnt", 32'(a_err), 0);
    chk("rst_last_data", 32'(a_last), 0);

    @(posedge clk); #1 rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("idle_no_req", 32'(a_reqs + a_loads), 0);

    // Clean run
    a_begin();
    wait_done("clean", 0, 2000);
    a_run_counts("clean");
    chk("clean_settle_gap", 32'(a_first - a_loadc - 1), 64);
    chk("clean_contiguous", 32'(a_lastc - a_first + 1), 256);
    repeat (3) @(negedge clk);
    chk("clean_done_held", 32'({a_done, a_pass, a_busy}), 3'b110);

    // Injected errors
    mem[17]  = 8'h00;
    mem[200] = 8'h55;
    a_begin();
    wait_done("errs", 0, 2000);
    a_run_counts("errs");
    mem[17]  = 8'd17;
    mem[200] = 8'd200;

    // Stalls: RD_READY toggled every 3 cycles
    a_tog = 0;
    a_stall = 1'b1;
    a_begin();
    wait_done("stall", 0, 4000);
    a_run_counts("stall");
    a_stall = 1'b0;
    a_ready = 1'b1;

    // Reset mid-run
    a_begin();
    a_wait_reqs("rst_reach_100", 100);
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_outputs", 32'({a_req, a_load, a_busy, a_done, a_pass}), 0);
    chk("midrst_err_cnt", 32'(a_err), 0);
    chk("midrst_first_err", 32'({a_fea, a_fed}), 0);
    chk("midrst_last_data", 32'(a_last), 0);
    if (sb.size() > 0) void'(sb.pop_front());
    repeat (2) @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    a_reqs = 0; a_loads = 0;
    repeat (5) @(negedge clk);
    chk("postrst_idle", 32'({a_busy, 8'(a_reqs), 8'(a_loads)}), 0);
    a_begin();
    wait_done("postrst", 0, 2000);
    a_run_counts("postrst");

    // Second START at read 50 is ignored
    a_begin();
    a_wait_reqs("busy_reach_50", 50);
    @(posedge clk); #1 a_start = 1'b1;
    @(posedge clk); #1 a_start = 1'b0;
    wait_done("busy", 0, 2000);
    repeat (80) @(negedge clk);
    a_run_counts("busy");
    chk("busy_single_done", 32'(a_dones), 5);

    // Pattern wrap, 512 words
    eb.err = '0; eb.pass = 1'b1; eb.fea = '0; eb.fed = '0; eb.last = 8'hFF;
    sb.push_back(eb);
    b_reqs = 0; b_loads = 0; b_didx = 0;
    @(posedge clk); #1 b_start = 1'b1;
    @(posedge clk); #1 b_start = 1'b0;
    wait_done("wrap", 1, 2000);
    chk("wrap_req_cnt", 32'(b_reqs), 512);
    chk("wrap_load_cnt", 32'(b_loads), 1);

    // Saturation, 65536 mismatching words
    ec.err = 16'hFFFF; ec.pass = 1'b0; ec.fea = '0;
    ec.fed = CAP ? 8'hFF : 8'h00; ec.last = 8'h00;
    sb.push_back(ec);
    c_reqs = 0; c_loads = 0; c_didx = 0;
    @(posedge clk); #1 c_start = 1'b1;
    @(posedge clk); #1 c_start = 1'b0;
    wait_done("sat", 2, 70000);
    chk("sat_req_cnt", 32'(c_reqs), 65536);
    chk("sat_load_cnt", 32'(c_loads), 1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/sdram_rd_checker.md
SDRAM_RD_CHECKER -- requirements
Module: sdram_rd_checker

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning the width of the read FIFO data word.
REQ-002 The block SHALL have parameter NUM_WORDS, default 256, meaning the number of words checked per run (a power of two, at least 2).
REQ-003 The block SHALL have parameter SETTLE_CYC, default 64, meaning the idle cycles after RD_LOAD before the first read, for controller prefetch.
REQ-004 The block SHALL have port REF_CLK  in  1  single clock; all logic rising-edge.
REQ-005 The block SHALL have port RESET_N  in  1  asynchronous active-low reset.
REQ-006 The block SHALL have port START  in  1  one-cycle pulse that begins a check run.
REQ-007 The block SHALL have port RD_READY  in  1  read FIFO holds data (not empty).
REQ-008 The block SHALL have port RD_DATA  in  DATA_W  read FIFO data, valid exactly 1 cycle after RD_REQ.
REQ-009 The block SHALL have port RD_REQ  out  1  read strobe to the controller read port 1.
REQ-010 The block SHALL have port RD_LOAD  out  1  read address reload pulse to the controller.
REQ-011 The block SHALL have port BUSY  out  1  a run is in progress.
REQ-012 The block SHALL have port DONE  out  1  the run is finished, held until the next START.
REQ-013 The block SHALL have port PASS  out  1  DONE and zero mismatches.
REQ-014 The block SHALL have port ERR_CNT  out  16  mismatch count.
REQ-015 The block SHALL have port FIRST_ERR_ADDR  out  log2(NUM_WORDS)  word index of the first mismatch.
REQ-016 The block SHALL have port FIRST_ERR_DATA  out  DATA_W  data read at the first mismatch.
REQ-017 The block SHALL have port LAST_DATA  out  DATA_W  last word received, for the HEX display.

Function
REQ-018 The FSM SHALL use the states IDLE, LOAD, SETTLE, READ, DRAIN and FINISH.
REQ-019 In IDLE, a START pulse SHALL move the FSM to LOAD, clear ERR_CNT, FIRST_ERR_*, DONE and PASS, and set BUSY.
REQ-020 LOAD SHALL assert RD_LOAD for exactly 1 cycle and then move to SETTLE.
REQ-021 SETTLE SHALL count SETTLE_CYC cycles and then move to READ.
REQ-022 In READ, RD_REQ SHALL equal RD_READY, and the request index SHALL increment on each RD_REQ.
REQ-023 READ SHALL move to DRAIN on the same cycle that the NUM_WORDS-th RD_REQ is issued.
REQ-024 DRAIN SHALL last 1 cycle, to capture the final RD_DATA, and then move to FINISH.
REQ-025 FINISH SHALL last 1 cycle: it sets DONE, sets PASS = (ERR_CNT==0), clears BUSY and returns to IDLE.
REQ-026 Expected data for word i SHALL be i mod 2^DATA_W, so the pattern wraps when NUM_WORDS > 2^DATA_W.
REQ-027 The compare SHALL be registered: on the cycle after an RD_REQ, RD_DATA is compared with the expected value of that request's index.
REQ-028 Each mismatch SHALL increment ERR_CNT, which saturates at 16'hFFFF.
REQ-029 Every compared word SHALL update LAST_DATA.
REQ-030 START while BUSY SHALL be ignored.
REQ-031 A START on the same cycle as FINISH SHALL be ignored.
REQ-032 RD_READY low in READ SHALL stall the run with no timeout, and the request index SHALL hold.
REQ-033 RD_REQ SHALL never be asserted outside READ.
REQ-034 At most NUM_WORDS requests SHALL be issued per run.

Reset
REQ-035 Asserting RESET_N low at any time, including mid-run, SHALL immediately force the FSM to IDLE.
REQ-036 During reset, every output and counter SHALL be 0: RD_REQ, RD_LOAD, BUSY, DONE, PASS, ERR_CNT, FIRST_ERR_*, LAST_DATA.
REQ-037 After release, the first active edge SHALL only sample START; no read SHALL be issued until START.

Configuration
REQ-038 Macro SDRAM_RD_CHECKER_ERR_CAPTURE_EN, when defined, SHALL capture FIRST_ERR_ADDR/FIRST_ERR_DATA on the first mismatch of a run and hold them until the next START.
REQ-039 When SDRAM_RD_CHECKER_ERR_CAPTURE_EN is undefined, FIRST_ERR_ADDR and FIRST_ERR_DATA SHALL be constant 0, with no capture registers; all other behaviour is unchanged.

Structure
REQ-040 Package sdram_rd_checker_pkg SHALL hold the FSM state enum type, the ERR_CNT width (16), and the saturation constant.
REQ-041 Sub-module sdram_rd_cmp SHALL hold the expected-pattern generator, the registered comparator, the saturating ERR_CNT and the first-error capture; the top level holds the FSM and the request counter.

Verification
REQ-042 The bench SHALL cover a clean run: memory model 0..255 and RD_READY always 1; START -> RD_LOAD 1 cycle, 64 idle cycles, 256 consecutive RD_REQ, DONE=1, PASS=1, ERR_CNT=0, LAST_DATA=8'hFF.
REQ-043 The bench SHALL cover injected errors: word 17 = 8'h00 and word 200 = 8'h55 -> ERR_CNT=2, PASS=0, FIRST_ERR_ADDR=17, FIRST_ERR_DATA=8'h00 (macro on); both 0 with the macro off.
REQ-044 The bench SHALL cover stalls: RD_READY toggled every 3 cycles -> exactly 256 RD_REQ, none while RD_READY=0, PASS=1.
REQ-045 The bench SHALL cover reset mid-run: RESET_N low after 100 reads -> all outputs 0 during reset; a new START yields a full clean 256-word run.
REQ-046 The bench SHALL cover START while busy: a second START at read 50 -> ignored, exactly one RD_LOAD, one run of 256 reads.
REQ-047 The bench SHALL cover saturation: DATA_W=8, NUM_WORDS=65536 (/=4 overridden), all-mismatch data -> ERR_CNT stops at 16'hFFFF; also the pattern wrap check with NUM_WORDS=512 and data i mod 256 -> PASS=1.
